uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 106 ++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with valid/ready output and single-cycle error pulses.
// Even parity bit is added when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DAT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DAT_WIDTH-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(DAT_WIDTH);
    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;
    state_t state, state_n;
    logic rx_meta, rxs;
    logic [CW-1:0] baud;
    logic [BW-1:0] bit_cnt;
    logic [DAT_WIDTH-1:0] shreg;
    logic mid, last_bit, stop_hit, good, par_bad;
    // START decides at half a bit so every later sample lands mid-bit
    assign mid = baud == ((state == START) ? CW'(CLOCKS_PER_BIT/2 - 1) : CW'(CLOCKS_PER_BIT - 1));
    assign last_bit = bit_cnt == BW'(DAT_WIDTH - 1);
    assign stop_hit = state == STOP && mid;
    assign good = stop_hit && rxs && !par_bad;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rxs ? IDLE : START;
            START:   state_n = !mid ? START : rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    state_n = (mid && last_bit) ? PARITY : DATA;
            PARITY:  state_n = mid ? STOP : PARITY;
`else
            DATA:    state_n = (mid && last_bit) ? STOP : DATA;
`endif
            STOP:    state_n = !mid ? STOP : rxs ? IDLE : BREAK;
            BREAK:   state_n = rxs ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            rx_meta <= rx;
            rxs     <= rx_meta;
            baud    <= (mid || state == IDLE || state_n != state) ? '0 : baud + 1'b1;
            if (state == DATA && mid) begin
                shreg   <= {rxs, shreg[DAT_WIDTH-1:1]};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end
    // A handshake in the same cycle as a good frame frees the slot for the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_hit && !rxs;
            overrun   <= good && valid && !ready;
            if (good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
`ifdef UART_RX_PARITY_EN
    logic par_hit;
    assign par_hit = state == PARITY && mid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_hit && ((^shreg) != rxs);
            if (par_hit) par_bad <= (^shreg) != rxs;
        end
    end
`else
    assign par_bad = 1'b0;
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level scoreboard for uart_rx.
module tb_uart_rx;
    localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + CPB/2 + (8 + 1 + PB) * CPB;
    localparam int K_VAL = 0, K_OVR = 1, K_FERR = 2, K_PERR = 3;
    typedef struct {
        int kind;
        logic [7:0] d;
        int t0;
    } ev_t;
    logic clk = 0, rst_n = 0, rx = 1, ready = 0;
    logic [7:0] data;
    logic valid, frame_err, overrun, parity_err;
    int checks = 0, failures = 0, cyc = 0;
    bit full = 0;
    logic valid_q = 0;
    logic [7:0] data_q = 0;
    ev_t exp_q[$];

    uart_rx #(.CLOCKS_PER_BIT(CPB), .DAT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic got(input int k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event got kind=%0d data=%0h expected no event", k, d);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        if (k == K_VAL && e.kind == K_VAL) begin
            chk("event_data", d, e.d);
            checks++;
            if (cyc - e.t0 < LAT - 1 || cyc - e.t0 > LAT + 1) begin
                failures++;
                $display("FAIL latency got=%0d expected=%0d+/-1", cyc - e.t0, LAT);
            end
        end
    endtask

    // Monitor: every output event pops the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_q = 0;
        end else begin
            if (parity_err) got(K_PERR, data);
            if (frame_err) got(K_FERR, data);
            if (overrun) got(K_OVR, data);
            if (valid && !valid_q) got(K_VAL, data);
            if (valid && valid_q) chk("data_hold", data, data_q);
            valid_q = valid;
            data_q = data;
        end
    end

    task automatic push(input int k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.d = d;
        e.t0 = cyc;
        exp_q.push_back(e);
    endtask

    // Reference: a good frame fills the single-word slot or overruns if it is occupied
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int hold);
        @(negedge clk);
        rx = 0;
        if (!par_ok) push(K_PERR, 8'h00);
        if (!stop_ok) push(K_FERR, 8'h00);
        else if (par_ok) begin
            push(full ? K_OVR : K_VAL, d);
            full = 1;
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? ^d : ~^d;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_ok;
        repeat (CPB + (stop_ok ? 0 : hold)) @(negedge clk);
        rx = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        chk("valid_before_ready", valid, 1);
        ready = 1;
        @(negedge clk);
        ready = 0;
        chk("valid_fall_after_ready", valid, 0);
        full = 0;
    endtask

    task automatic glitch();
        @(negedge clk);
        rx = 0;
        @(negedge clk);
        rx = 1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        bit s_ok, p_ok;
        repeat (3) @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_parity_err", parity_err, 0);
        rst_n = 1;
        repeat (4) @(negedge clk);

        send_frame(8'hA5, 1, 1, 0);
        chk("data_a5", data, 8'hA5);
        consume();

        send_frame(8'h3C, 1, 1, 0);
        send_frame(8'h81, 1, 1, 0);
        chk("data_kept_3c", data, 8'h3C);
        consume();

        send_frame(8'h55, 0, 1, 20);
        chk("valid_after_frame_err", valid, 0);
        send_frame(8'h12, 1, 1, 0);
        chk("data_12", data, 8'h12);
        consume();

        glitch();
        chk("valid_after_glitch", valid, 0);

        send_frame(8'h33, 1, 1, 0);
        @(negedge clk);
        rx = 0;
        repeat (CPB) @(negedge clk);
        rx = 1;
        repeat (CPB * 3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_reset_valid", valid, 0);
        chk("async_reset_data", data, 0);
        chk("async_reset_errs", {frame_err, overrun, parity_err}, 0);
        full = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        chk("valid_after_reset_release", valid, 0);
        send_frame(8'h0F, 1, 1, 0);
        chk("data_0f", data, 8'h0F);
        consume();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 0, 0);
        chk("valid_after_parity_err", valid, 0);
        send_frame(8'h07, 1, 1, 0);
        chk("data_07", data, 8'h07);
        consume();
`endif

        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            s_ok = $urandom_range(0, 6) != 0;
            p_ok = (PB == 0) || ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) glitch();
            send_frame(d, s_ok, p_ok, $urandom_range(0, 20));
            if (full && $urandom_range(0, 1) == 1) consume();
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
